axi4lite_reg_bridge: RTL and testbench

AXI4-Lite subordinate front end of the timer register block. It consumes the `axi4lite_intf` `sp` modport driven by the bus master and converts each read or write transaction into a single-cycle-addressed register access with a ready/error handshake. The register file sits directly behind it. There is one outstanding access at a time, read/write arbitration is fair, and a bus-hang timeout is included.

---
 rtl/axi4lite_reg_bridge_if.sv | 62 ++++++
 rtl/axi4lite_reg_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_axi4lite_reg_bridge.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_reg_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4lite_intf
//  Purpose  : AXI4-Lite bus bundle shared by a bus master and a subordinate.
//             No clock or reset is carried; both ends run on their own clk.
//  Modports : sp - subordinate view (bridge side)
//             mp - master view (initiator side)
//  Revision : 1.0 - initial release
// ============================================================================
interface axi4lite_intf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 1
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Write address channel
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [3:0]            aw_qos;
    // Write data channel
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    // Write response channel
    logic                  b_valid;
    logic                  b_ready;
    logic [RESP_WIDTH-1:0] b_resp;
    // Read address channel
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [3:0]            ar_qos;
    // Read data channel
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [RESP_WIDTH-1:0] r_resp;

    modport sp (
        input  aw_valid, aw_addr, aw_qos,
        input  w_valid, w_data, w_strb,
        input  b_ready,
        input  ar_valid, ar_addr, ar_qos,
        input  r_ready,
        output aw_ready, w_ready, b_valid, b_resp,
        output ar_ready, r_valid, r_data, r_resp
    );

    modport mp (
        output aw_valid, aw_addr, aw_qos,
        output w_valid, w_data, w_strb,
        output b_ready,
        output ar_valid, ar_addr, ar_qos,
        output r_ready,
        input  aw_ready, w_ready, b_valid, b_resp,
        input  ar_ready, r_valid, r_data, r_resp
    );
endinterface
`default_nettype wire

// File: rtl/axi4lite_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : axi4lite_reg_bridge
//  Purpose  : AXI4-Lite subordinate front end for the timer register block.
//             Buffers AW/W/AR in 1-entry skid registers, arbitrates fairly
//             between reads and writes, issues one register access at a time
//             and returns the AXI response. A hung access is force-completed
//             with an error after TIMEOUT_CYCLES request cycles.
//  Ports    : clk_i, arstn_i     - clock, asynchronous active-low reset
//             s_axi (sp)         - AXI4-Lite subordinate port
//             reg_req_o/we/addr/wdata/wstrb - register access request
//             reg_ready_i/rdata_i/err_i     - register access completion
//  Revision : 1.0 - initial release
// ============================================================================
module axi4lite_reg_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RESP_WIDTH     = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    axi4lite_intf.sp                s_axi,
    output logic                    reg_req_o,
    output logic                    reg_we_o,
    output logic [ADDR_WIDTH-1:0]   reg_addr_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb_o,
    input  logic                    reg_ready_i,
    input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
    input  logic                    reg_err_i
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RRESP = 2'd2,
        BRESP = 2'd3
    } state_t;

    state_t                  state_q, state_d;

    // Ready outputs stay low during reset and for the first cycle after it.
    logic                    live_q;

    // Skid buffers; address bits [1:0] are never stored.
    logic                    aw_full_q;
    logic [ADDR_WIDTH-1:2]   aw_addr_q;
    logic                    w_full_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_WIDTH-1:0]   w_strb_q;
    logic                    ar_full_q;
    logic [ADDR_WIDTH-1:2]   ar_addr_q;

    // In-flight access
    logic                    rd_first_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:2]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic                    aw_hs, w_hs, ar_hs;
    logic                    wr_pend, rd_pend;
    logic                    grant_rd, grant_wr;
    logic                    req_done, req_tmo;

    assign s_axi.aw_ready = live_q && !aw_full_q;
    assign s_axi.w_ready  = live_q && !w_full_q;
    assign s_axi.ar_ready = live_q && (state_q == IDLE) && !ar_full_q;

    assign aw_hs = s_axi.aw_valid && s_axi.aw_ready;
    assign w_hs  = s_axi.w_valid  && s_axi.w_ready;
    assign ar_hs = s_axi.ar_valid && s_axi.ar_ready;

    assign wr_pend = aw_full_q && w_full_q;
    assign rd_pend = ar_full_q;

    assign s_axi.r_valid = (state_q == RRESP);
    assign s_axi.r_data  = rdata_q;
    assign s_axi.r_resp  = {RESP_WIDTH{err_q}};
    assign s_axi.b_valid = (state_q == BRESP);
    assign s_axi.b_resp  = {RESP_WIDTH{err_q}};

    assign reg_req_o   = (state_q == REQ);
    assign reg_we_o    = we_q;
    assign reg_addr_o  = {addr_q, 2'b00};
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = wstrb_q;

    // QoS and sub-word address bits carry no meaning for a word register file.
    logic unused_ok;
    assign unused_ok = ^{s_axi.aw_qos, s_axi.ar_qos,
                         s_axi.aw_addr[1:0], s_axi.ar_addr[1:0]};

    always_comb begin
        state_d  = state_q;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        req_done = 1'b0;
        req_tmo  = 1'b0;
        case (state_q)
            IDLE: begin
                // rd_first_q breaks the tie only when both kinds are waiting.
                if (rd_pend && (rd_first_q || !wr_pend)) begin
                    grant_rd = 1'b1;
                    state_d  = REQ;
                end else if (wr_pend) begin
                    grant_wr = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // A completion on the final allowed cycle beats the timeout.
                if (reg_ready_i) begin
                    req_done = 1'b1;
                    state_d  = we_q ? BRESP : RRESP;
                end else if (cnt_q == CNT_LAST) begin
                    req_tmo = 1'b1;
                    state_d = we_q ? BRESP : RRESP;
                end
            end
            RRESP: if (s_axi.r_ready) state_d = IDLE;
            BRESP: if (s_axi.b_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            live_q     <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            ar_full_q  <= 1'b0;
            ar_addr_q  <= '0;
            rd_first_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            live_q <= 1'b1;

            // A buffer is never accepted and granted in the same cycle,
            // since its ready is low while it is full.
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= s_axi.aw_addr[ADDR_WIDTH-1:2];
            end else if (grant_wr) begin
                aw_full_q <= 1'b0;
            end

            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= s_axi.w_data;
                w_strb_q <= s_axi.w_strb;
            end else if (grant_wr) begin
                w_full_q <= 1'b0;
            end

            if (ar_hs) begin
                ar_full_q <= 1'b1;
                ar_addr_q <= s_axi.ar_addr[ADDR_WIDTH-1:2];
            end else if (grant_rd) begin
                ar_full_q <= 1'b0;
            end

            if (grant_rd || grant_wr) begin
                rd_first_q <= ~rd_first_q;
                we_q       <= grant_wr;
                cnt_q      <= '0;
                if (grant_wr) begin
                    addr_q  <= aw_addr_q;
                    wdata_q <= w_data_q;
                    wstrb_q <= w_strb_q;
                end else begin
                    addr_q  <= ar_addr_q;
                end
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (req_done) begin
                err_q <= reg_err_i;
                if (!we_q) rdata_q <= reg_rdata_i;
            end else if (req_tmo) begin
                err_q <= 1'b1;
                if (!we_q) rdata_q <= '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi4lite_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4lite_reg_bridge
//  Purpose  : Self-checking bench for axi4lite_reg_bridge. A behavioural
//             register file answers reg_* requests with programmable wait,
//             error and hang; a word-level memory model predicts read data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_reg_bridge;
    localparam int BUDGET   = 200;
    localparam int TMO      = 16;
    localparam logic [31:0] ERR_DATA = 32'hBADC_0DE5;

    logic        clk;
    logic        arstn;
    logic        reg_req, reg_we, reg_ready, reg_err;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic [3:0]  reg_wstrb;

    int checks = 0;
    int errors = 0;

    axi4lite_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_WIDTH(1)) s_axi ();

    axi4lite_reg_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_WIDTH(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i      (clk),
        .arstn_i    (arstn),
        .s_axi      (s_axi),
        .reg_req_o  (reg_req),
        .reg_we_o   (reg_we),
        .reg_addr_o (reg_addr),
        .reg_wdata_o(reg_wdata),
        .reg_wstrb_o(reg_wstrb),
        .reg_ready_i(reg_ready),
        .reg_rdata_i(reg_rdata),
        .reg_err_i  (reg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural register file ----------------
    int          resp_wait = 0;
    bit          resp_err  = 1'b0;
    bit          resp_hang = 1'b0;
    int          req_cycles = 0;
    bit          in_req = 1'b0;
    int          wcnt = 0;
    logic [31:0] last_addr, last_wdata, rsp_v;
    logic [3:0]  last_wstrb;
    logic        last_we;
    bit          grant_log[$];
    logic [31:0] rf_mem  [logic [31:0]];
    logic [31:0] exp_mem [logic [31:0]];

    initial begin
        reg_ready = 1'b0;
        reg_rdata = '0;
        reg_err   = 1'b0;
        forever begin
            @(negedge clk);
            reg_ready = 1'b0;
            reg_rdata = '0;
            reg_err   = 1'b0;
            if (reg_req === 1'b1) begin
                req_cycles++;
                if (!in_req) begin
                    in_req     = 1'b1;
                    wcnt       = 0;
                    grant_log.push_back(reg_we);
                    last_we    = reg_we;
                    last_addr  = reg_addr;
                    last_wdata = reg_wdata;
                    last_wstrb = reg_wstrb;
                end
                if (!resp_hang) begin
                    if (wcnt >= resp_wait) begin
                        reg_ready = 1'b1;
                        reg_err   = resp_err;
                        rsp_v = rf_mem.exists(reg_addr) ? rf_mem[reg_addr] : 32'h0;
                        reg_rdata = resp_err ? ERR_DATA : rsp_v;
                        if (reg_we && !resp_err) begin
                            for (int b = 0; b < 4; b++)
                                if (reg_wstrb[b]) rsp_v[8*b +: 8] = reg_wdata[8*b +: 8];
                            rf_mem[reg_addr] = rsp_v;
                        end
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                in_req = 1'b0;
            end
        end
    end

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
    endfunction

    // ---------------- bus driver tasks (called at a negedge) ----------------
    task automatic axi_aw_w(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit do_aw, input bit do_w,
                            output bit ok);
        bit aw_pend, w_pend, aw_go, w_go;
        int n;
        aw_pend = do_aw;
        w_pend  = do_w;
        n = 0;
        if (do_aw) begin
            s_axi.aw_valid = 1'b1; s_axi.aw_addr = addr; s_axi.aw_qos = 4'($urandom);
        end
        if (do_w) begin
            s_axi.w_valid = 1'b1; s_axi.w_data = data; s_axi.w_strb = strb;
        end
        while ((aw_pend || w_pend) && n < BUDGET) begin
            aw_go = aw_pend && s_axi.aw_ready;
            w_go  = w_pend  && s_axi.w_ready;
            @(negedge clk);
            n++;
            if (aw_go) begin aw_pend = 1'b0; s_axi.aw_valid = 1'b0; end
            if (w_go)  begin w_pend  = 1'b0; s_axi.w_valid  = 1'b0; end
        end
        s_axi.aw_valid = 1'b0;
        s_axi.w_valid  = 1'b0;
        ok = !(aw_pend || w_pend);
    endtask

    task automatic axi_ar(input logic [31:0] addr, output bit ok);
        bit go;
        int n;
        n = 0;
        go = 1'b0;
        s_axi.ar_valid = 1'b1; s_axi.ar_addr = addr; s_axi.ar_qos = 4'($urandom);
        while (!go && n < BUDGET) begin
            go = s_axi.ar_ready;
            @(negedge clk);
            n++;
        end
        s_axi.ar_valid = 1'b0;
        ok = go;
    endtask

    // lat counts cycles from the handshake cycle to the first valid cycle.
    task automatic wait_b(output bit ok, output int lat);
        lat = 1;
        while (!s_axi.b_valid && lat < BUDGET) begin @(negedge clk); lat++; end
        ok = s_axi.b_valid;
    endtask

    task automatic wait_r(output bit ok, output int lat);
        lat = 1;
        while (!s_axi.r_valid && lat < BUDGET) begin @(negedge clk); lat++; end
        ok = s_axi.r_valid;
    endtask

    task automatic accept_b();
        s_axi.b_ready = 1'b1; @(negedge clk); s_axi.b_ready = 1'b0;
    endtask

    task automatic accept_r();
        s_axi.r_ready = 1'b1; @(negedge clk); s_axi.r_ready = 1'b0;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        arstn = 1'b0;
        s_axi.aw_valid = 0; s_axi.aw_addr = 0; s_axi.aw_qos = 0;
        s_axi.w_valid = 0;  s_axi.w_data = 0;  s_axi.w_strb = 0;
        s_axi.ar_valid = 0; s_axi.ar_addr = 0; s_axi.ar_qos = 0;
        s_axi.b_ready = 0;  s_axi.r_ready = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_axi.aw_ready, s_axi.w_ready, s_axi.ar_ready, s_axi.r_valid,
             s_axi.b_valid, reg_req} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=000000", {s_axi.aw_ready, s_axi.w_ready,
                     s_axi.ar_ready, s_axi.r_valid, s_axi.b_valid, reg_req});
        end
        checks++;
        if (reg_addr !== 0 || reg_wdata !== 0 || reg_wstrb !== 0 || s_axi.r_data !== 0 ||
            s_axi.r_resp !== 0 || s_axi.b_resp !== 0) begin
            errors++;
            $display("FAIL reset_data addr=%h wdata=%h wstrb=%h rdata=%h rresp=%b bresp=%b exp all 0",
                     reg_addr, reg_wdata, reg_wstrb, s_axi.r_data, s_axi.r_resp, s_axi.b_resp);
        end
        arstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_axi.aw_ready, s_axi.w_ready, s_axi.ar_ready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset got=%b exp=111",
                     {s_axi.aw_ready, s_axi.w_ready, s_axi.ar_ready});
        end
    endtask

    task automatic test_write_same_cycle();
        bit ok, okb, hold_ok;
        int lat;
        resp_wait = 0; resp_err = 0;
        axi_aw_w(32'h8, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, ok);
        wait_b(okb, lat);
        checks++;
        if (!ok || !okb || lat !== 3) begin
            errors++;
            $display("FAIL wr_latency hs=%0d bvalid=%0d lat=%0d exp=3", ok, okb, lat);
        end
        checks++;
        if (last_we !== 1'b1 || last_addr !== 32'h8 || last_wdata !== 32'hDEAD_BEEF ||
            last_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL wr_reg_side we=%b addr=%h wdata=%h strb=%h exp 1/8/deadbeef/f",
                     last_we, last_addr, last_wdata, last_wstrb);
        end
        hold_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (s_axi.b_valid !== 1'b1 || s_axi.b_resp !== 1'b0) hold_ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!hold_ok || s_axi.b_valid !== 1'b1) begin
            errors++;
            $display("FAIL b_hold bvalid=%b bresp=%b exp 1/0 for 4 cycles",
                     s_axi.b_valid, s_axi.b_resp);
        end
        accept_b();
        checks++;
        if (s_axi.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL b_release bvalid=%b exp=0", s_axi.b_valid);
        end
    endtask

    task automatic test_read_wait();
        bit ok, okr, hold_ok;
        int lat;
        rf_mem[32'hC] = 32'h1234_5678;
        resp_wait = 2; resp_err = 0;
        axi_ar(32'hE, ok);
        wait_r(okr, lat);
        checks++;
        if (!ok || !okr || lat !== 5) begin
            errors++;
            $display("FAIL rd_latency hs=%0d rvalid=%0d lat=%0d exp=5", ok, okr, lat);
        end
        checks++;
        if (last_we !== 1'b0 || last_addr !== 32'hC) begin
            errors++;
            $display("FAIL rd_reg_side we=%b addr=%h exp 0/0000000c", last_we, last_addr);
        end
        hold_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (s_axi.r_valid !== 1'b1 || s_axi.r_data !== 32'h1234_5678 ||
                s_axi.r_resp !== 1'b0) hold_ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL rd_data_hold rdata=%h rresp=%b exp 12345678/0",
                     s_axi.r_data, s_axi.r_resp);
        end
        accept_r();
        resp_wait = 0;
    endtask

    task automatic test_arbitration();
        int n;
        do_reset();
        resp_wait = 0; resp_err = 0;
        rf_mem[32'h18] = 32'hCAFE_0018;
        grant_log.delete();
        for (int pair = 0; pair < 2; pair++) begin
            s_axi.ar_valid = 1'b1; s_axi.ar_addr = 32'h10 + 32'(pair * 8);
            s_axi.aw_valid = 1'b1; s_axi.aw_addr = 32'h14 + 32'(pair * 8);
            s_axi.w_valid  = 1'b1; s_axi.w_data  = $urandom; s_axi.w_strb = 4'hF;
            checks++;
            if ({s_axi.ar_ready, s_axi.aw_ready, s_axi.w_ready} !== 3'b111) begin
                errors++;
                $display("FAIL arb_ready pair=%0d got=%b exp=111", pair,
                         {s_axi.ar_ready, s_axi.aw_ready, s_axi.w_ready});
            end
            @(negedge clk);
            s_axi.ar_valid = 1'b0; s_axi.aw_valid = 1'b0; s_axi.w_valid = 1'b0;
            s_axi.r_ready = 1'b1; s_axi.b_ready = 1'b1;
            n = 0;
            while ((grant_log.size() < 2 * (pair + 1) || reg_req || s_axi.r_valid ||
                    s_axi.b_valid) && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
            s_axi.r_ready = 1'b0; s_axi.b_ready = 1'b0;
            checks++;
            if (grant_log.size() !== 2 * (pair + 1)) begin
                errors++;
                $display("FAIL arb_grants pair=%0d got=%0d exp=%0d", pair,
                         grant_log.size(), 2 * (pair + 1));
            end else if (grant_log[2*pair] !== 1'b0 || grant_log[2*pair+1] !== 1'b1) begin
                errors++;
                $display("FAIL arb_order pair=%0d got=%b%b exp=01 (read then write)", pair,
                         grant_log[2*pair], grant_log[2*pair+1]);
            end
        end
    endtask

    task automatic test_w_before_aw();
        bit ok, okb, quiet;
        int lat;
        resp_wait = 0; resp_err = 0;
        axi_aw_w(32'h0, 32'h0BAD_F00D, 4'h5, 1'b0, 1'b1, ok);
        checks++;
        if (!ok || s_axi.w_ready !== 1'b0) begin
            errors++;
            $display("FAIL w_first_ready hs=%0d wready=%b exp 1/0", ok, s_axi.w_ready);
        end
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (reg_req !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL w_first_no_req reg_req seen=1 exp=0");
        end
        axi_aw_w(32'h23, 32'h0, 4'h0, 1'b1, 1'b0, ok);
        wait_b(okb, lat);
        checks++;
        if (!ok || !okb || lat !== 3 || s_axi.b_resp !== 1'b0 || last_we !== 1'b1 ||
            last_addr !== 32'h20 || last_wdata !== 32'h0BAD_F00D || last_wstrb !== 4'h5) begin
            errors++;
            $display("FAIL w_first_write lat=%0d bresp=%b we=%b addr=%h wdata=%h strb=%h exp 3/0/1/20/0badf00d/5",
                     lat, s_axi.b_resp, last_we, last_addr, last_wdata, last_wstrb);
        end
        accept_b();
    endtask

    task automatic test_timeout();
        bit ok, okr;
        int lat;
        resp_hang = 1'b1;
        req_cycles = 0;
        axi_ar(32'h30, ok);
        wait_r(okr, lat);
        checks++;
        if (!ok || !okr || req_cycles !== TMO || lat !== TMO + 2) begin
            errors++;
            $display("FAIL timeout_len req_cycles=%0d lat=%0d exp %0d/%0d",
                     req_cycles, lat, TMO, TMO + 2);
        end
        checks++;
        if (s_axi.r_resp !== 1'b1 || s_axi.r_data !== 32'h0) begin
            errors++;
            $display("FAIL timeout_resp rresp=%b rdata=%h exp 1/00000000",
                     s_axi.r_resp, s_axi.r_data);
        end
        accept_r();
        resp_hang = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok, okr;
        int lat;
        resp_hang = 1'b1;
        axi_ar(32'h40, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || reg_req !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre reg_req=%b exp=1", reg_req);
        end
        #2 arstn = 1'b0;
        #1;
        checks++;
        if ({reg_req, s_axi.ar_ready, s_axi.aw_ready, s_axi.w_ready, s_axi.r_valid,
             s_axi.b_valid} !== 6'b0 || reg_addr !== 32'h0) begin
            errors++;
            $display("FAIL arst_async ctrl=%b addr=%h exp 000000/00000000",
                     {reg_req, s_axi.ar_ready, s_axi.aw_ready, s_axi.w_ready,
                      s_axi.r_valid, s_axi.b_valid}, reg_addr);
        end
        @(negedge clk);
        arstn = 1'b1;
        resp_hang = 1'b0;
        resp_wait = 0; resp_err = 0;
        repeat (2) @(negedge clk);
        rf_mem[32'h44] = 32'h5EED_0044;
        axi_ar(32'h44, ok);
        wait_r(okr, lat);
        checks++;
        if (!ok || !okr || lat !== 3 || s_axi.r_data !== 32'h5EED_0044 ||
            s_axi.r_resp !== 1'b0) begin
            errors++;
            $display("FAIL arst_fresh_read lat=%0d rdata=%h rresp=%b exp 3/5eed0044/0",
                     lat, s_axi.r_data, s_axi.r_resp);
        end
        accept_r();
    endtask

    task automatic test_random();
        bit ok, ok2, okv, is_wr;
        int lat, order;
        logic [31:0] addr, data, waddr, ev;
        logic [3:0]  strb;
        rf_mem.delete();
        exp_mem.delete();
        for (int t = 0; t < 40; t++) begin
            is_wr     = 1'($urandom_range(0, 1));
            addr      = 32'($urandom_range(0, 63));
            waddr     = addr & ~32'h3;
            data      = $urandom;
            strb      = 4'($urandom);
            resp_wait = $urandom_range(0, 3);
            resp_err  = ($urandom_range(0, 4) == 0);
            if (is_wr) begin
                order = $urandom_range(0, 2);
                if (order == 0) begin
                    axi_aw_w(addr, data, strb, 1'b1, 1'b1, ok); ok2 = 1'b1;
                end else if (order == 1) begin
                    axi_aw_w(addr, data, strb, 1'b0, 1'b1, ok);
                    axi_aw_w(addr, data, strb, 1'b1, 1'b0, ok2);
                end else begin
                    axi_aw_w(addr, data, strb, 1'b1, 1'b0, ok);
                    axi_aw_w(addr, data, strb, 1'b0, 1'b1, ok2);
                end
                wait_b(okv, lat);
                checks++;
                if (!ok || !ok2 || !okv || lat !== 3 + resp_wait ||
                    s_axi.b_resp !== 1'(resp_err)) begin
                    errors++;
                    $display("FAIL rnd_wr_resp t=%0d lat=%0d bresp=%b exp %0d/%b",
                             t, lat, s_axi.b_resp, 3 + resp_wait, resp_err);
                end
                checks++;
                if (last_we !== 1'b1 || last_addr !== waddr || last_wdata !== data ||
                    last_wstrb !== strb) begin
                    errors++;
                    $display("FAIL rnd_wr_req t=%0d we=%b addr=%h wdata=%h strb=%h exp 1/%h/%h/%h",
                             t, last_we, last_addr, last_wdata, last_wstrb, waddr, data, strb);
                end
                if (!resp_err) begin
                    ev = model_rd(waddr);
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) ev[8*b +: 8] = data[8*b +: 8];
                    exp_mem[waddr] = ev;
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                accept_b();
            end else begin
                axi_ar(addr, ok);
                wait_r(okv, lat);
                ev = resp_err ? ERR_DATA : model_rd(waddr);
                checks++;
                if (!ok || !okv || lat !== 3 + resp_wait || last_we !== 1'b0 ||
                    last_addr !== waddr) begin
                    errors++;
                    $display("FAIL rnd_rd_req t=%0d lat=%0d we=%b addr=%h exp %0d/0/%h",
                             t, lat, last_we, last_addr, 3 + resp_wait, waddr);
                end
                checks++;
                if (s_axi.r_data !== ev || s_axi.r_resp !== 1'(resp_err)) begin
                    errors++;
                    $display("FAIL rnd_rd_data t=%0d rdata=%h rresp=%b exp %h/%b",
                             t, s_axi.r_data, s_axi.r_resp, ev, resp_err);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                accept_r();
            end
        end
        resp_wait = 0;
        resp_err  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_read_wait();
        test_arbitration();
        test_w_before_aw();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
